ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 device-to-host receiver inside Microcomputer. It consumes the keyboard clock/data lines driven by mist_io (ps2_kbd_clk/ps2_kbd_data) and turns them into scancode bytes for the CPU-side keyboard register. It filters and samples the line clock, deserialises 11-bit frames, checks framing and parity, and buffers good bytes in a small FIFO with a valid/ready read port.

Parameters:
FILTER_LEN, 8, consecutive equal clk_sys samples needed before filtered ps2_clk changes (2..255)
TIMEOUT_CYC, 65536, clk_sys cycles without a falling edge mid-frame before the frame is aborted
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries

Ports:
clk_sys  in  1  system clock; all logic is on its rising edge
n_reset  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock line (asynchronous)
ps2_data  in  1  raw PS/2 data line (asynchronous)
rx_data  out  10  FIFO head: [7:0] scancode; [9:8] = {ext, release} with PS2_RX_PREFIX_EN, else 0
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer pops the head when rx_valid && rx_ready
frame_err  out  1  one-cycle pulse on a discarded frame
err_code  out  2  cause of the last error: 0 none, 1 parity, 2 stop, 3 timeout; held until the next error
overflow  out  1  sticky; set when a good byte is dropped because the FIFO is full; cleared only by reset
busy  out  1  high while state != IDLE

Behaviour:
- Reset values: rx_data 0, rx_valid 0, frame_err 0, err_code 0, overflow 0, busy 0, FIFO empty, state IDLE.
- Synchronisers: ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Clock filter: an 8-bit counter counts synchronised ps2_clk samples that differ from the filtered value. The filtered value toggles when the count reaches FILTER_LEN-1. Any matching sample resets the count. The filtered clock resets to 1.
- Sample point: the cycle after a filtered 1->0 edge. Data is sampled from the synchronised ps2_data.
- State IDLE: on a falling edge with data=0 (start bit), go to SHIFT with bitcnt=0. Data=1 is ignored and the state stays IDLE.
- State SHIFT: each falling edge shifts data into the shift register LSB-first and increments bitcnt.
  - bitcnt 0..7 are data bits, 8 is parity, 9 is stop.
  - After the stop bit, go to CHECK.
- State CHECK (one cycle):
  - Odd-parity fail gives err 1. Stop bit 0 gives err 2.
  - On error: pulse frame_err and load err_code; the byte is dropped.
  - Otherwise push the byte to the FIFO (via the prefix logic when enabled).
  - Return to IDLE.
- Timeout: in SHIFT a counter is reset on every falling edge. Reaching TIMEOUT_CYC gives frame_err, err_code=3, and a return to IDLE.
- FIFO:
  - Registered read port: rx_data/rx_valid reflect the head with no extra latency; a pop advances the head next cycle.
  - Push and pop on the same cycle are both honoured, including when the FIFO is full.
  - Push while full without a pop drops the byte and sets overflow.
- Latency: the push occurs 2 clk_sys cycles after the filtered stop-bit falling edge. rx_valid rises the cycle after the push.
- Reset mid-frame clears everything; partial frames are lost.

Optional Feature:
PS2_RX_PREFIX_EN.
- Defined:
  - A good byte 0xE0 sets the pending ext bit, and 0xF0 sets the pending release bit. Neither byte is pushed.
  - The next other byte is pushed as {ext, release, code}, then both pending bits clear.
  - A frame error or timeout also clears both pending bits.
- Undefined: every good byte is pushed raw and rx_data[9:8]=0.

Decomposition:
- Package ps2_pkg:
  - err_code localparams ERR_NONE/PARITY/STOP/TIMEOUT.
  - State enum {IDLE, SHIFT, CHECK}.
  - PREFIX_EXT=8'hE0 and PREFIX_REL=8'hF0.
- Sub-module ps2_rx_fifo (parameterised by width 10 and FIFO_AW, with full/empty) is natural. The filter, FSM and prefix logic stay in the top module.

Test Plan:
- Good frame: send 0x1C with parity 0 and stop 1 at a 12 kHz line clock -> rx_data=0x01C, rx_valid=1, frame_err never pulses. Pop with rx_ready=1 -> rx_valid=0.
- Parity error: send 0x1C with parity 1 -> no push, one frame_err pulse, err_code=1. A following 0x29 frame (parity 0) is received OK and err_code stays 1.
- Timeout/reset: send start plus 4 bits, then hold the lines high for >TIMEOUT_CYC -> frame_err, err_code=3, busy=0. Next 0x5A is received correctly. Separately, assert n_reset mid-frame -> all outputs go to their reset values immediately.
- Overflow: with FIFO_AW=2 and rx_ready=0, send 0x11,0x22,0x33,0x44,0x55 -> overflow=1. Pops return 0x11..0x44 in order, then rx_valid=0.
- Glitch: inject a ps2_clk low pulse of FILTER_LEN-2 cycles while idle and mid-frame -> no bit is shifted, and the following frame 0x1C decodes correctly.
- Prefix (macro on): send E0,F0,74 -> exactly one push, rx_data=0x374. Then sending 74 -> 0x074. Without the macro the same E0,F0,74 sequence yields three pushes: 0x0E0, 0x0F0, 0x074.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared error codes, receiver states and scancode prefixes for the PS/2 receiver.
package ps2_pkg;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_STOP    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
    localparam logic [7:0] PREFIX_EXT  = 8'hE0;
    localparam logic [7:0] PREFIX_REL  = 8'hF0;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: small FIFO with a registered head; push and pop together are honoured even when full.
module ps2_rx_fifo #(
    parameter int W  = 10,
    parameter int AW = 2
) (
    input  logic         clk_sys,
    input  logic         n_reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0] mem_q [2**AW];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic wr_en, rd_en;
    assign full_o  = cnt_q == (AW+1)'(2**AW);
    assign empty_o = cnt_q == '0;
    assign rd_en   = pop_i && !empty_o;
    // when full, the slot being written is the head that is popped this same cycle
    assign wr_en   = push_i && (!full_o || pop_i);
    assign data_o  = mem_q[rd_q];
    always_ff @(posedge clk_sys or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (rd_en) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 device-to-host receiver: clock filter, 11-bit frame checker, byte FIFO.
// Define PS2_RX_PREFIX_EN to fold E0/F0 prefix bytes into rx_data[9:8].
module ps2_kbd_rx import ps2_pkg::*; #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 65536,
    parameter int FIFO_AW     = 2
) (
    input  logic       clk_sys,
    input  logic       n_reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overflow,
    output logic       busy
);
    logic [1:0] clk_sync_q, dat_sync_q;
    logic filt_q, filt_prev_q, fall;
    logic [7:0] flt_cnt_q;
    state_t state_q;
    logic [3:0] bitcnt_q;
    logic [9:0] shift_q;
    logic [31:0] to_cnt_q;
    logic frame_err_q, overflow_q;
    logic [1:0] err_code_q;
    logic par_ok, stop_ok, good, is_prefix, push, pop, fifo_full, fifo_empty;
    logic [9:0] push_data;
    assign fall    = filt_prev_q && !filt_q;
    assign par_ok  = ^shift_q[8:0];
    assign stop_ok = shift_q[9];
    assign good    = state_q == CHECK && par_ok && stop_ok;
    assign push    = good && !is_prefix;
    assign pop     = rx_valid && rx_ready;
    always_ff @(posedge clk_sys or negedge n_reset) begin
        if (!n_reset) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            flt_cnt_q   <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            dat_sync_q  <= {dat_sync_q[0], ps2_data};
            filt_prev_q <= filt_q;
            if (clk_sync_q[1] == filt_q) flt_cnt_q <= '0;
            else if (flt_cnt_q == 8'(FILTER_LEN - 1)) begin
                filt_q    <= !filt_q;
                flt_cnt_q <= '0;
            end else flt_cnt_q <= flt_cnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk_sys or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (push && fifo_full && !pop) overflow_q <= 1'b1;
            case (state_q)
                IDLE: if (fall && !dat_sync_q[1]) begin
                    state_q  <= SHIFT;
                    bitcnt_q <= '0;
                    to_cnt_q <= '0;
                end
                SHIFT: if (fall) begin
                    shift_q  <= {dat_sync_q[1], shift_q[9:1]};
                    bitcnt_q <= bitcnt_q + 4'd1;
                    to_cnt_q <= '0;
                    if (bitcnt_q == 4'd9) state_q <= CHECK;
                end else if (to_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
                    state_q     <= IDLE;
                    frame_err_q <= 1'b1;
                    err_code_q  <= ERR_TIMEOUT;
                end else to_cnt_q <= to_cnt_q + 32'd1;
                CHECK: begin
                    state_q <= IDLE;
                    if (!par_ok || !stop_ok) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= !par_ok ? ERR_PARITY : ERR_STOP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef PS2_RX_PREFIX_EN
    logic ext_q, rel_q;
    assign is_prefix = shift_q[7:0] == PREFIX_EXT || shift_q[7:0] == PREFIX_REL;
    assign push_data = {ext_q, rel_q, shift_q[7:0]};
    always_ff @(posedge clk_sys or negedge n_reset) begin
        if (!n_reset) {ext_q, rel_q} <= 2'b00;
        else if (frame_err_q) {ext_q, rel_q} <= 2'b00;
        else if (good) begin
            if (shift_q[7:0] == PREFIX_EXT) ext_q <= 1'b1;
            else if (shift_q[7:0] == PREFIX_REL) rel_q <= 1'b1;
            else {ext_q, rel_q} <= 2'b00;
        end
    end
`else
    assign is_prefix = 1'b0;
    assign push_data = {2'b00, shift_q[7:0]};
`endif
    ps2_rx_fifo #(.W(10), .AW(FIFO_AW)) u_fifo (
        .clk_sys (clk_sys),
        .n_reset (n_reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .data_o  (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign overflow  = overflow_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: randomized PS/2 frames against a byte-level reference model with a scoreboard.
module tb_ps2_kbd_rx;
    localparam int FL = 8, TO = 2500, AW = 2, DEPTH = 4, H = 40;
    logic clk_sys = 0, n_reset = 0, ps2_clk = 1, ps2_data = 1, rx_ready = 0;
    logic [9:0] rx_data;
    logic rx_valid, frame_err, overflow, busy;
    logic [1:0] err_code;
    int checks = 0, errors = 0, occ = 0;
    logic [9:0] exp_q[$];
    logic [1:0] err_q[$];
    logic exp_ovf = 0, pend_ext = 0, pend_rel = 0;
    logic [1:0] exp_code = 0;

    always #5 clk_sys = ~clk_sys;

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_AW(AW)) dut (
        .clk_sys(clk_sys), .n_reset(n_reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
        .err_code(err_code), .overflow(overflow), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_sys) if (n_reset) begin
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_byte: got %03h with nothing expected", rx_data);
            end else begin
                check("rx_data", rx_data, exp_q.pop_front());
                occ--;
            end
        end
        if (frame_err) begin
            if (err_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_frame_err: err_code %0d with no error expected", err_code);
            end else check("err_code_pulse", err_code, err_q.pop_front());
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic deliver(input logic [9:0] v);
        if (occ == DEPTH) exp_ovf = 1;
        else begin
            exp_q.push_back(v);
            occ++;
        end
    endtask

    task automatic model_err(input logic [1:0] c);
        err_q.push_back(c);
        exp_code = c;
        pend_ext = 0;
        pend_rel = 0;
    endtask

    task automatic model(input logic [7:0] b, input logic pbad, input logic sbad);
        if (pbad || sbad) model_err(pbad ? 2'd1 : 2'd2);
        else begin
`ifdef PS2_RX_PREFIX_EN
            if (b == 8'hE0) begin pend_ext = 1; return; end
            if (b == 8'hF0) begin pend_rel = 1; return; end
`endif
            deliver({pend_ext, pend_rel, b});
            pend_ext = 0;
            pend_rel = 0;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(H);
        ps2_clk = 0;
        wait_cyc(H);
        ps2_clk = 1;
    endtask

    task automatic glitch();
        wait_cyc(20);
        ps2_clk = 0;
        wait_cyc(FL - 2);
        ps2_clk = 1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pbad, input logic sbad, input int glitch_at);
        logic [10:0] f;
        f = {~sbad, (~^b) ^ pbad, b, 1'b0};
        model(b, pbad, sbad);
        for (int i = 0; i < 11; i++) begin
            send_bit(f[i]);
            if (i == glitch_at) glitch();
        end
        ps2_data = 1;
        wait_cyc(60);
        check("err_code_hold", err_code, exp_code);
        check("busy_idle", busy, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) wait_cyc(1);
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] b;
        logic [10:0] f;
        int k;
        wait_cyc(5);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        n_reset = 1;
        rx_ready = 1;
        wait_cyc(5);

        send_frame(8'h1C, 0, 0, -1);
        drain();
        check("valid_after_pop", rx_valid, 0);

        send_frame(8'h1C, 1, 0, -1);
        send_frame(8'h29, 0, 0, -1);
        drain();
        check("err_code_kept", err_code, 1);

        f = {1'b1, ~^8'hA5, 8'hA5, 1'b0};
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        ps2_data = 1;
        model_err(2'd3);
        wait_cyc(20);
        check("busy_mid_frame", busy, 1);
        wait_cyc(TO + 100);
        check("busy_after_timeout", busy, 0);
        check("err_code_timeout", err_code, 3);
        send_frame(8'h5A, 0, 0, -1);

        ps2_data = 0;
        glitch();
        wait_cyc(30);
        ps2_data = 1;
        check("busy_after_idle_glitch", busy, 0);
        send_frame(8'h1C, 0, 0, 3);
        drain();

        send_frame(8'hE0, 0, 0, -1);
        send_frame(8'hF0, 0, 0, -1);
        send_frame(8'h74, 0, 0, -1);
        send_frame(8'h74, 0, 0, -1);
        drain();

        for (int n = 0; n < 16; n++) begin
            k = $urandom_range(0, 5);
            send_frame(8'($urandom), k == 0, k == 1, -1);
        end
        drain();

        rx_ready = 0;
        for (int n = 0; n < 5; n++) begin
            do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
            send_frame(b, 0, 0, -1);
        end
        check("overflow_set", overflow, exp_ovf);
        check("valid_when_full", rx_valid, 1);
        rx_ready = 1;
        drain();
        wait_cyc(2);
        check("valid_after_drain", rx_valid, 0);

        send_frame(8'h33, 1, 0, -1);
        f = {1'b1, ~^8'h3C, 8'h3C, 1'b0};
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        #3 n_reset = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err_code", err_code, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_frame_err", frame_err, 0);
        occ = 0; exp_ovf = 0; pend_ext = 0; pend_rel = 0; exp_code = 0;
        ps2_data = 1;
        ps2_clk = 1;
        wait_cyc(5);
        n_reset = 1;
        wait_cyc(5);
        send_frame(8'h1C, 0, 0, -1);
        drain();
        check("overflow_after_rst", overflow, 0);

        for (int i = 0; i < 200 && err_q.size() != 0; i++) wait_cyc(1);
        check("err_queue_empty", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
